// File: rtl/imem_sync.sv
// imem_sync: synchronous instruction memory with a valid/ready fetch port,
// a program-load write port and branch-redirect flush.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   fetch request present
//   req_ready  out  fetch can be accepted this cycle (IDLE, no flush, no reset)
//   req_pc     in   byte address of the instruction [ADDR_W]
//   rsp_valid  out  response present
//   rsp_ready  in   consumer takes the response this cycle
//   rsp_instr  out  fetched instruction [DATA_W], zero when rsp_valid=0
//   rsp_err    out  misaligned or out-of-range fetch
//   flush      in   drop any in-flight or pending fetch
//   ld_en      in   program-load write strobe
//   ld_addr    in   load word index [log2(DEPTH)]
//   ld_data    in   load word [DATA_W]
module imem_sync #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_pc,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_instr,
    output logic                     rsp_err,
    input  logic                     flush,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data
);

    localparam int BYTES   = DATA_W / 8;
    localparam int ALIGN_W = $clog2(BYTES);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam logic [1:0]        CNT_INIT   = 2'(LATENCY - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_cnt;
    logic [1:0]        w_cnt_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_data;
    logic              r_err;

    logic [ADDR_W-1:0] w_idx;
    logic [IDX_W-1:0]  w_ridx;
    logic              w_misalign;
    logic              w_oor;
    logic              w_fault;
    logic              w_accept;
    logic              w_ld_ok;

    assign w_idx      = req_pc >> ALIGN_W;
    assign w_ridx     = IDX_W'(w_idx);
    assign w_misalign = (req_pc & ALIGN_MASK) != '0;
    assign w_oor      = 32'(w_idx) >= 32'(DEPTH);
    assign w_fault    = w_misalign | w_oor;

    // Reset and flush both block acceptance so neither can race a new fetch.
    assign req_ready  = (r_state == S_IDLE) && !flush && !rst;
    assign w_accept   = req_valid && req_ready;
    assign w_ld_ok    = !rst && ld_en && (32'(ld_addr) < 32'(DEPTH));

    // Response outputs are gated by state, so the latched data needs no reset.
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_instr  = rsp_valid ? r_data : '0;
    assign rsp_err    = rsp_valid & r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (LATENCY == 1) begin
                            w_state_nxt = S_RESP;
                        end else begin
                            w_state_nxt = S_WAIT;
                            w_cnt_nxt   = CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Leaving on count 1 makes RESP visible after LATENCY-1
                    // further edges, so the response is sampled LATENCY
                    // edges after acceptance.
                    if (r_cnt <= 2'd1) begin
                        w_state_nxt = S_RESP;
                        w_cnt_nxt   = 2'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    // No accept here: req_ready is low outside IDLE, so the
                    // next fetch is taken the cycle after consumption.
                    if (rsp_ready) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The read uses the pre-edge array value, so a same-cycle load to the
    // same index returns the old word.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data <= w_fault ? '0 : r_mem[w_ridx];
            r_err  <= w_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ld_ok) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

endmodule

// File: doc/imem_sync.md
IMEM_SYNC -- requirements
Module: imem_sync

Interface
REQ-001 Parameter DATA_W, default 16, instruction width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 16, byte-address (PC) width.
REQ-003 Parameter DEPTH, default 256, number of instruction words stored.
REQ-004 Parameter LATENCY, default 1, cycles from request accept to response valid; legal range 1..4.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  1  fetch request present.
REQ-008 req_ready  output  1  block can accept a fetch this cycle.
REQ-009 req_pc  input  ADDR_W  byte address of the requested instruction.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  consumer accepts the response this cycle.
REQ-012 rsp_instr  output  DATA_W  fetched instruction.
REQ-013 rsp_err  output  1  fetch fault: misaligned or out-of-range PC.
REQ-014 flush  input  1  cancel any in-flight or pending fetch (branch redirect).
REQ-015 ld_en  input  1  program-load write strobe.
REQ-016 ld_addr  input  log2(DEPTH)  word index for the load write.
REQ-017 ld_data  input  DATA_W  word written on load.

Function
REQ-018 Word index SHALL be req_pc >> log2(DATA_W/8); the low log2(DATA_W/8) bits are the alignment bits.
REQ-019 States: IDLE, WAIT, RESP; at most one fetch outstanding.
REQ-020 req_ready SHALL be 1 only in IDLE with flush=0.
REQ-021 Request accepted when req_valid & req_ready; memory read at the word index occurs in the accept cycle; captured index, data and fault latched.
REQ-022 On accept: if LATENCY=1 go to RESP; else go to WAIT with counter loaded to LATENCY-1.
REQ-023 WAIT: counter decrements each cycle; on reaching 0 go to RESP; rsp_valid asserts exactly LATENCY cycles after the accept edge.
REQ-024 RESP: rsp_valid=1; rsp_instr, rsp_err held stable until rsp_valid & rsp_ready, then go to IDLE.
REQ-025 Back-to-back throughput: a new request SHALL NOT be accepted in the same cycle a response is consumed; next accept earliest the following cycle.
REQ-026 Fault: alignment bits nonzero, or word index >= DEPTH -> rsp_err=1 and rsp_instr=0; memory not read out of range.
REQ-027 rsp_instr SHALL be 0 whenever rsp_valid=0.
REQ-028 flush=1 in any state: next state IDLE, counter cleared, rsp_valid=0 next cycle, pending response discarded; a request presented with flush=1 is not accepted.
REQ-029 Load write: when ld_en=1, mem[ld_addr] <= ld_data at the clock edge; ld_addr >= DEPTH ignored; loads allowed in every state.
REQ-030 Load/fetch collision on the same index in the accept cycle: fetch returns the old (pre-write) word.
REQ-031 A load after accept SHALL NOT change the latched response data.
REQ-032 Memory contents are not initialised by RTL; initialisation only via load port or simulation preload.

Reset
REQ-033 rst=1 at a clock edge: state IDLE, counter 0, rsp_valid=0, rsp_err=0, rsp_instr=0; in-flight fetch dropped.
REQ-034 req_ready=0 while rst=1; memory contents unaffected by reset; ld_en ignored while rst=1.
REQ-035 rst has priority over flush, ld_en and request accept.

Verification
REQ-036 LATENCY=1: load mem[0]=16'h0001, mem[1]=16'h0002; fetch pc=2 -> rsp_valid next cycle, rsp_instr=16'h0002, rsp_err=0.
REQ-037 LATENCY=3: fetch pc=0 at cycle t with rsp_ready=0 for 5 cycles -> rsp_valid at t+3, rsp_instr=16'h0001 held stable until rsp_ready, req_ready=0 throughout.
REQ-038 Faults: pc=16'h0003 -> rsp_err=1, rsp_instr=0; pc=16'h0200 (index 256, DEPTH=256) -> rsp_err=1, rsp_instr=0.
REQ-039 Flush: LATENCY=4, accept pc=0, assert flush at accept+2 -> rsp_valid never asserts for that fetch, req_ready=1 the cycle after flush deasserts.
REQ-040 Collision: mem[5]=16'hAAAA; ld_en to index 5 with 16'h5555 in the accept cycle of pc=10 -> rsp_instr=16'hAAAA; refetch pc=10 -> 16'h5555.
REQ-041 Reset mid-fetch: LATENCY=2, rst at accept+1 -> all outputs 0 next cycle, memory word previously loaded still returned on subsequent fetch.
